// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle ARM control unit: FSM states,
// instruction-field encodings, ALU control codes, condition codes and flag indices.
package ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9
   } state_t;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/multicycle_controller_cond_check.sv
// Condition evaluation against the NZCV register, and the NZCV register itself
// with independent write gating for {N,Z} and {C,V}.
module cond_check
   import ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] i_cond,
   input  logic [3:0] i_alu_flags,
   input  logic [1:0] i_flag_w,
   input  logic       i_flag_en,
   output logic       o_cond_ex,
   output logic [3:0] o_flags
);

   logic [3:0] r_flags;
   logic       w_n, w_z, w_c, w_v, w_ge;

   assign w_n  = r_flags[FLAG_N];
   assign w_z  = r_flags[FLAG_Z];
   assign w_c  = r_flags[FLAG_C];
   assign w_v  = r_flags[FLAG_V];
   assign w_ge = (w_n == w_v);

   always_comb begin
      o_cond_ex = 1'b0;
      case (i_cond)
         COND_EQ: o_cond_ex = w_z;
         COND_NE: o_cond_ex = ~w_z;
         COND_CS: o_cond_ex = w_c;
         COND_CC: o_cond_ex = ~w_c;
         COND_MI: o_cond_ex = w_n;
         COND_PL: o_cond_ex = ~w_n;
         COND_VS: o_cond_ex = w_v;
         COND_VC: o_cond_ex = ~w_v;
         COND_HI: o_cond_ex = w_c & ~w_z;
         COND_LS: o_cond_ex = ~w_c | w_z;
         COND_GE: o_cond_ex = w_ge;
         COND_LT: o_cond_ex = ~w_ge;
         COND_GT: o_cond_ex = ~w_z & w_ge;
         COND_LE: o_cond_ex = w_z | ~w_ge;
         COND_AL: o_cond_ex = 1'b1;
         default: o_cond_ex = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_flags <= 4'b0000;
      end else if (i_flag_en) begin
         if (i_flag_w[1]) r_flags[FLAG_N:FLAG_Z] <= i_alu_flags[FLAG_N:FLAG_Z];
         if (i_flag_w[0]) r_flags[FLAG_C:FLAG_V] <= i_alu_flags[FLAG_C:FLAG_V];
      end
   end

   assign o_flags = r_flags;

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the shared-resource multicycle ARM datapath.
// Define CTRL_MEM_WAIT_EN to stall FETCH/MEMRD/MEMWR until MemReady.
module multicycle_controller
   import ctrl_pkg::*;
#(
   parameter state_t RESET_STATE = FETCH
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] ALUFlags,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic       ALUSrcA,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic [1:0] ALUControl,
   output logic [3:0] Flags,
   output state_t     State
);

   state_t     r_state;
   logic       r_cond_ex;
   logic       w_cond_ex;
   logic       w_mem_ready;
   logic       w_alu_op, w_reg_w, w_mem_w, w_branch;
   logic       w_alu_valid, w_add_sub;
   logic [1:0] w_alu_ctl;
   logic [1:0] w_flag_w;
   logic       w_flag_en;
   logic       w_no_reset;

`ifdef CTRL_MEM_WAIT_EN
   assign w_mem_ready = MemReady;
`else
   logic w_unused_mem_ready;
   assign w_unused_mem_ready = MemReady;
   assign w_mem_ready        = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= RESET_STATE;
         r_cond_ex <= 1'b0;
      end else begin
         case (r_state)
            FETCH:  if (w_mem_ready) r_state <= DECODE;
            DECODE: begin
               r_cond_ex <= w_cond_ex;
               case (Op)
                  OP_MEM:  r_state <= MEMADR;
                  OP_DP:   r_state <= Funct[5] ? EXECI : EXECR;
                  OP_BR:   r_state <= BRANCH;
                  default: r_state <= FETCH;
               endcase
            end
            MEMADR: r_state <= Funct[0] ? MEMRD : MEMWR;
            MEMRD:  if (w_mem_ready) r_state <= MEMWB;
            MEMWR:  if (w_mem_ready) r_state <= FETCH;
            EXECR:  r_state <= ALUWB;
            EXECI:  r_state <= ALUWB;
            default: r_state <= FETCH;
         endcase
      end
   end

   // ALU command decode; unsupported commands write neither flags nor registers.
   always_comb begin
      w_alu_ctl   = ALU_ADD;
      w_alu_valid = 1'b1;
      w_add_sub   = 1'b0;
      case (Funct[4:1])
         4'b0100: begin w_alu_ctl = ALU_ADD; w_add_sub = 1'b1; end
         4'b0010: begin w_alu_ctl = ALU_SUB; w_add_sub = 1'b1; end
         4'b0000: w_alu_ctl = ALU_AND;
         4'b1100: w_alu_ctl = ALU_ORR;
         default: w_alu_valid = 1'b0;
      endcase
   end

   assign w_flag_w  = {Funct[0] & w_alu_valid, Funct[0] & w_add_sub};
   assign w_flag_en = ((r_state == EXECR) || (r_state == EXECI)) && r_cond_ex;

   cond_check u_cond_check (
      .clk         (clk),
      .reset       (reset),
      .i_cond      (Cond),
      .i_alu_flags (ALUFlags),
      .i_flag_w    (w_flag_w),
      .i_flag_en   (w_flag_en),
      .o_cond_ex   (w_cond_ex),
      .o_flags     (Flags)
   );

   always_comb begin
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcB   = 2'b00;
      w_alu_op  = 1'b0;
      w_reg_w   = 1'b0;
      w_mem_w   = 1'b0;
      w_branch  = 1'b0;
      case (r_state)
         FETCH:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
         DECODE: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
         MEMADR: ALUSrcB = 2'b01;
         MEMRD:  AdrSrc = 1'b1;
         MEMWB:  begin ResultSrc = 2'b01; w_reg_w = 1'b1; end
         MEMWR:  begin AdrSrc = 1'b1; w_mem_w = 1'b1; end
         EXECR:  w_alu_op = 1'b1;
         EXECI:  begin ALUSrcB = 2'b01; w_alu_op = 1'b1; end
         ALUWB:  w_reg_w = w_alu_valid;
         BRANCH: begin ALUSrcB = 2'b01; ResultSrc = 2'b10; w_branch = 1'b1; end
         default: ;
      endcase
   end

   always_comb begin
      ImmSrc = 2'b00;
      RegSrc = 2'b00;
      case (Op)
         OP_MEM: begin ImmSrc = 2'b01; RegSrc = Funct[0] ? 2'b00 : 2'b10; end
         OP_BR:  begin ImmSrc = 2'b10; RegSrc = 2'b01; end
         default: ;
      endcase
   end

   // A reset cycle must never commit a write, even though state updates only at the edge.
   assign w_no_reset = ~reset;
   assign ALUControl = w_alu_op ? w_alu_ctl : ALU_ADD;
   assign IRWrite    = w_no_reset & (r_state == FETCH) & w_mem_ready;
   assign RegWrite   = w_no_reset & w_reg_w & r_cond_ex;
   assign MemWrite   = w_no_reset & w_mem_w & r_cond_ex;
   assign PCWrite    = w_no_reset & (((r_state == FETCH) & w_mem_ready) |
                       (r_cond_ex & (w_branch | (w_reg_w & (Rd == 4'hF)))));
   assign State      = r_state;

endmodule
